// File: rtl/timer_pkg.sv
// Shared types, register map and mode decode for the timer_xn channels.
// TIMER_PWM_EN decides whether mode 2 decodes as PWM or falls back to periodic.
package timer_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAP_W  = 5;

   typedef enum logic [1:0] {
      ONESHOT  = 2'd0,
      PERIODIC = 2'd1,
      PWM      = 2'd2
   } mode_e;

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_LOAD  = 2'd1;
   localparam logic [1:0] REG_CMP   = 2'd2;
   localparam logic [1:0] REG_COUNT = 2'd3;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IE      = 3;
   localparam int unsigned CTRL_FLAG    = 7;
   localparam int unsigned CTRL_TAP_LO  = 8;
   localparam int unsigned CTRL_TAP_HI  = 12;

   // Reserved encoding 3 (and 2 without PWM support) runs as periodic.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      mode_e m;
      m = PERIODIC;
      if (raw == 2'd0) m = ONESHOT;
`ifdef TIMER_PWM_EN
      if (raw == 2'd2) m = PWM;
`endif
      return m;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/LOAD/CMP/COUNT state, expiry handling and waveform output.
// CMP storage and the PWM comparator exist only when TIMER_PWM_EN is defined.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned PRE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              wr_ctrl,
   input  logic              wr_load,
   input  logic              wr_cmp,
   input  logic              wr_count,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        sel,
   output logic [DATA_W-1:0] rdata_c,
   output logic              irq_c,
   output logic [TAP_W-1:0]  tap,
   output logic              ch_out
);

   logic             en, en_d;
   logic [1:0]       mode_raw, mode_d;
   logic             ie, ie_d;
   logic [TAP_W-1:0] tap_d, wtap;
   logic             flag, flag_d;
   logic [CNT_W-1:0] load, load_d;
   logic [CNT_W-1:0] count, count_d;
   logic             tog, tog_d;
   logic             ch_out_d;
   logic             active, expire;
`ifdef TIMER_PWM_EN
   logic [CNT_W-1:0] cmp, cmp_d;
`else
   logic             unused_cmp;
   assign unused_cmp = wr_cmp;
`endif
   logic             unused_wdata;
   assign unused_wdata = ^{wdata[CTRL_FLAG:CTRL_IE+1], wdata[DATA_W-1:CTRL_TAP_HI+1]};

   // A software disable in the same cycle as a tick freezes COUNT instead of stepping it.
   assign active = en && tick && !(wr_ctrl && !wdata[CTRL_EN]);
   assign expire = active && (count == '0);
   assign wtap   = wdata[CTRL_TAP_HI:CTRL_TAP_LO];
   assign irq_c  = flag & ie;

   always_comb begin
      en_d     = en;
      mode_d   = mode_raw;
      ie_d     = ie;
      tap_d    = tap;
      flag_d   = flag;
      load_d   = load;
      count_d  = count;
      tog_d    = tog;
      ch_out_d = ch_out;
`ifdef TIMER_PWM_EN
      cmp_d    = cmp;
`endif
      if (wr_ctrl) begin
         en_d   = wdata[CTRL_EN];
         mode_d = wdata[CTRL_MODE_HI:CTRL_MODE_LO];
         ie_d   = wdata[CTRL_IE];
         tap_d  = (wtap > TAP_W'(PRE_W)) ? TAP_W'(PRE_W) : wtap;
         if (wdata[CTRL_EN] && !en) begin
            count_d = load;
            tog_d   = 1'b0;
         end
      end
      if (wr_load) begin
         load_d = wdata[CNT_W-1:0];
         if (!en) count_d = wdata[CNT_W-1:0];
      end
`ifdef TIMER_PWM_EN
      if (wr_cmp) cmp_d = wdata[CNT_W-1:0];
`endif
      if (wr_count) flag_d = 1'b0;
      if (active) begin
         if (expire) begin
            flag_d = 1'b1;
            case (decode_mode(mode_raw))
               ONESHOT: en_d = 1'b0;
               PWM:     count_d = load;
               default: begin
                  count_d = load;
                  tog_d   = ~tog;
               end
            endcase
         end else begin
            count_d = count - CNT_W'(1);
         end
      end
      // Waveform follows the post-edge state so it changes on the same edge as the flag.
      case (decode_mode(mode_d))
         ONESHOT: ch_out_d = en_d;
`ifdef TIMER_PWM_EN
         PWM:     if (en_d) ch_out_d = (count_d < cmp_d);
`endif
         default: ch_out_d = tog_d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en       <= 1'b0;
         mode_raw <= 2'd0;
         ie       <= 1'b0;
         tap      <= '0;
         flag     <= 1'b0;
         load     <= '0;
         count    <= '0;
         tog      <= 1'b0;
         ch_out   <= 1'b0;
`ifdef TIMER_PWM_EN
         cmp      <= '0;
`endif
      end else begin
         en       <= en_d;
         mode_raw <= mode_d;
         ie       <= ie_d;
         tap      <= tap_d;
         flag     <= flag_d;
         load     <= load_d;
         count    <= count_d;
         tog      <= tog_d;
         ch_out   <= ch_out_d;
`ifdef TIMER_PWM_EN
         cmp      <= cmp_d;
`endif
      end
   end

   always_comb begin
      rdata_c = '0;
      case (sel)
         REG_CTRL: begin
            rdata_c[CTRL_EN]                   = en;
            rdata_c[CTRL_MODE_HI:CTRL_MODE_LO] = mode_raw;
            rdata_c[CTRL_IE]                   = ie;
            rdata_c[CTRL_FLAG]                 = flag;
            rdata_c[CTRL_TAP_HI:CTRL_TAP_LO]   = tap;
         end
         REG_LOAD:  rdata_c = DATA_W'(load);
`ifdef TIMER_PWM_EN
         REG_CMP:   rdata_c = DATA_W'(cmp);
`endif
         REG_COUNT: rdata_c = DATA_W'(count);
         default:   rdata_c = '0;
      endcase
   end

endmodule

// File: rtl/timer_xn.sv
// Multi-channel programmable timer: shared prescaler, register decode, read mux and irq.
// Define TIMER_PWM_EN to build PWM mode and the CMP registers.
module timer_xn
   import timer_pkg::*;
#(
   parameter int unsigned CH_NUM = 4,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned PRE_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [1+$clog2(CH_NUM):0]   addr,
   input  logic [31:0]                 wdata,
   output logic [31:0]                 rdata,
   output logic                        irq,
   output logic [CH_NUM-1:0]           ch_out
);

   localparam int unsigned ADDR_W = 2 + $clog2(CH_NUM);
   localparam int unsigned SEL_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;

   logic [PRE_W-1:0]  pre;
   logic [SEL_W-1:0]  chan_sel;
   logic [1:0]        reg_sel;
   logic [31:0]       rdata_d;
   logic [CH_NUM-1:0] ch_irq;
   logic [CH_NUM-1:0] tick;
   logic [31:0]       ch_rd  [CH_NUM];
   logic [TAP_W-1:0]  ch_tap [CH_NUM];

   assign reg_sel = addr[1:0];

   generate
      if (ADDR_W > 2) begin : g_sel
         assign chan_sel = addr[ADDR_W-1:2];
      end else begin : g_sel_one
         assign chan_sel = SEL_W'(0);
      end
   endgenerate

   // A channel ticks when the low 'tap' prescaler bits are all zero.
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         tick[i] = 1'b1;
         for (int b = 0; b < PRE_W; b++) begin
            if ((b < int'(ch_tap[i])) && pre[b]) tick[i] = 1'b0;
         end
      end
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic hit;
      assign hit = we && (chan_sel == SEL_W'(i));

      timer_channel #(
         .CNT_W (CNT_W),
         .PRE_W (PRE_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick[i]),
         .wr_ctrl  (hit && (reg_sel == REG_CTRL)),
         .wr_load  (hit && (reg_sel == REG_LOAD)),
         .wr_cmp   (hit && (reg_sel == REG_CMP)),
         .wr_count (hit && (reg_sel == REG_COUNT)),
         .wdata    (wdata),
         .sel      (reg_sel),
         .rdata_c  (ch_rd[i]),
         .irq_c    (ch_irq[i]),
         .tap      (ch_tap[i]),
         .ch_out   (ch_out[i])
      );
   end

   // Unpopulated channel indices fall through to zero.
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (chan_sel == SEL_W'(i)) rdata_d = ch_rd[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre   <= '0;
         rdata <= '0;
         irq   <= 1'b0;
      end else begin
         pre   <= pre + PRE_W'(1);
         rdata <= rdata_d;
         irq   <= |ch_irq;
      end
   end

endmodule

// File: tb/tb_timer_xn.sv
// Directed self-checking bench for timer_xn (3 channels, 16-bit counters, 8-bit prescaler).
module tb_timer_xn;
   import timer_pkg::*;

   localparam int unsigned CH_NUM = 3;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PRE_W  = 8;
   localparam int unsigned ADDR_W = 2 + $clog2(CH_NUM);

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              irq;
   logic [CH_NUM-1:0] ch_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   timer_xn #(
      .CH_NUM (CH_NUM),
      .CNT_W  (CNT_W),
      .PRE_W  (PRE_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq),
      .ch_out (ch_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int r, input logic [31:0] d);
      we    = 1'b1;
      addr  = ADDR_W'((ch << 2) | r);
      wdata = d;
      step();
      we    = 1'b0;
   endtask

   task automatic rd(input int ch, input int r, output logic [31:0] d);
      addr = ADDR_W'((ch << 2) | r);
      step();
      d = rdata;
   endtask

   task automatic check_all_zero(input string pfx);
      logic [31:0] v;
      for (int ch = 0; ch < int'(CH_NUM); ch++) begin
         for (int r = 0; r < 4; r++) begin
            rd(ch, r, v);
            check($sformatf("%s ch%0d r%0d", pfx, ch, r), v, 32'h0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic        prev;
      int          ntog;
      int          tt [3];
      int          hi;

      rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
      repeat (3) step();
      rst = 1'b0;
      check("reset irq", 32'(irq), 32'h0);
      check("reset ch_out", 32'(ch_out), 32'h0);
      check("reset rdata", rdata, 32'h0);
      check_all_zero("reset");

      // One-shot countdown on ch0
      wr(0, REG_LOAD, 32'd3);
      wr(0, REG_CTRL, 32'h9);
      addr = ADDR_W'((0 << 2) | REG_COUNT);
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("oneshot count k%0d", k), rdata, 32'(3 - k));
         if (k == 0) check("oneshot ch_out high", 32'(ch_out[0]), 32'h1);
      end
      check("oneshot ch_out drop", 32'(ch_out[0]), 32'h0);
      check("oneshot irq lag", 32'(irq), 32'h0);
      step();
      check("oneshot irq", 32'(irq), 32'h1);
      rd(0, REG_CTRL, v);
      check("oneshot ctrl", v, 32'h88);
      wr(0, REG_COUNT, 32'hDEAD);
      step();
      check("flag clear irq", 32'(irq), 32'h0);

      // Periodic on ch1 with tap=2
      wr(1, REG_LOAD, 32'd1);
      wr(1, REG_CTRL, 32'h203);
      check("periodic ch_out start", 32'(ch_out[1]), 32'h0);
      prev = ch_out[1];
      ntog = 0;
      tt = '{0, 0, 0};
      for (int c = 1; c <= 60 && ntog < 3; c++) begin
         step();
         if (ch_out[1] !== prev) begin
            tt[ntog] = c;
            ntog++;
            prev = ch_out[1];
         end
      end
      check("periodic toggles", 32'(ntog), 32'd3);
      check("periodic interval1", 32'(tt[1] - tt[0]), 32'd8);
      check("periodic interval2", 32'(tt[2] - tt[1]), 32'd8);
      rd(1, REG_CTRL, v);
      check("periodic ctrl", v, 32'h283);
      check("periodic no irq", 32'(irq), 32'h0);

      // Expiry and clear-write on the same edge
      wr(0, REG_LOAD, 32'd0);
      wr(0, REG_CTRL, 32'h1);
      wr(0, REG_COUNT, 32'd0);
      rd(0, REG_CTRL, v);
      check("set wins", v, 32'h80);

      // Mode 2 on ch2
      wr(2, REG_LOAD, 32'd9);
      wr(2, REG_CMP, 32'd3);
      rd(2, REG_CMP, v);
`ifdef TIMER_PWM_EN
      check("cmp readback", v, 32'd3);
`else
      check("cmp absent", v, 32'd0);
`endif
      wr(2, REG_CTRL, 32'h5);
      hi = 0;
      for (int c = 0; c < 20; c++) begin step(); hi += int'(ch_out[2]); end
`ifdef TIMER_PWM_EN
      check("pwm duty 3/10", 32'(hi), 32'd6);
      wr(2, REG_CMP, 32'd0);
      hi = 0;
      for (int c = 0; c < 20; c++) begin step(); hi += int'(ch_out[2]); end
      check("pwm cmp0", 32'(hi), 32'd0);
      wr(2, REG_CMP, 32'd12);
      hi = 0;
      for (int c = 0; c < 20; c++) begin step(); hi += int'(ch_out[2]); end
      check("pwm cmp>load", 32'(hi), 32'd20);
      rd(2, REG_CMP, v);
      check("cmp readback 12", v, 32'd12);
`else
      check("mode2 as periodic", 32'(hi), 32'd10);
`endif

      // Width truncation and tap saturation
      wr(2, REG_LOAD, 32'h12345);
      rd(2, REG_LOAD, v);
      check("load truncate", v, 32'h2345);
      wr(1, REG_CTRL, 32'h1F02);
      rd(1, REG_CTRL, v);
      check("tap saturate", v, 32'h882);

      // Channel index beyond CH_NUM
      wr(3, REG_LOAD, 32'h55);
      rd(3, REG_LOAD, v);
      check("oob load", v, 32'h0);
      rd(3, REG_CTRL, v);
      check("oob ctrl", v, 32'h0);
      rd(0, REG_LOAD, v);
      check("oob no alias", v, 32'h0);

      // Reset in the middle of activity
      wr(0, REG_LOAD, 32'd100);
      wr(0, REG_CTRL, 32'h1);
      wr(1, REG_CTRL, 32'hB);
      step();
      step();
      check("pre-rst irq", 32'(irq), 32'h1);
      check("pre-rst ch_out0", 32'(ch_out[0]), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst irq", 32'(irq), 32'h0);
      check("rst ch_out", 32'(ch_out), 32'h0);
      check("rst rdata", rdata, 32'h0);
      check_all_zero("post-rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
